// File: rtl/reg_file_param.sv
// Parametrised integer register file: two combinational read ports, one write port,
// optional hardwired-zero entry 0, optional write-to-read forwarding and a sequential clear engine.
module reg_file_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] INADDRESS,
  input  logic [DATA_WIDTH-1:0] IN,
  input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
  input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
  output logic [DATA_WIDTH-1:0] OUT1,
  output logic [DATA_WIDTH-1:0] OUT2,
  input  logic                  CLEAR,
  output logic                  BUSY
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } state_t;

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   cnt_reg;
  logic                    busy_reg;
  logic                    clearing;
  logic                    write_accept;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   rd1_data;
  logic [DATA_WIDTH-1:0]   rd2_data;

  assign clearing = (state_reg == CLEARING);

  // A write to the hardwired zero entry is treated as never accepted, so it is not forwarded either.
  assign write_accept = RESET && WRITE && !busy_reg &&
                        !(ZERO_REG && (INADDRESS == '0));

  // Clear engine: one entry per cycle, completion detected by compare rather than counter wrap.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
    end else if (state_reg == IDLE) begin
      if (CLEAR) begin
        state_reg <= CLEARING;
        cnt_reg   <= '0;
        busy_reg  <= 1'b1;
      end
    end else begin
      if (cnt_reg == LAST_ADDR) begin
        state_reg <= IDLE;
        cnt_reg   <= '0;
        busy_reg  <= 1'b0;
      end else begin
        cnt_reg <= cnt_reg + ADDR_WIDTH'(1);
      end
    end
  end

  assign BUSY = busy_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      if (ZERO_REG && (gi == 0)) begin : g_zero
        assign mem_q[gi] = '0;
      end else begin : g_reg
        logic [DATA_WIDTH-1:0] entry_reg;

        always_ff @(posedge CLK or negedge RESET) begin
          if (!RESET) begin
            entry_reg <= '0;
          end else if (clearing && (cnt_reg == ADDR_WIDTH'(gi))) begin
            entry_reg <= '0;
          end else if (write_accept && (INADDRESS == ADDR_WIDTH'(gi))) begin
            entry_reg <= IN;
          end
        end

        assign mem_q[gi] = entry_reg;
      end
    end
  endgenerate

  function automatic logic [DATA_WIDTH-1:0] resolve_read(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] stored
  );
    logic [DATA_WIDTH-1:0] data;
    data = stored;
    if (BYPASS && write_accept && (INADDRESS == addr))
      data = IN;
    if (ZERO_REG && (addr == '0))
      data = '0;
    return data;
  endfunction

  always_comb begin
    rd1_data = resolve_read(OUT1ADDRESS, mem_q[OUT1ADDRESS]);
  end

  always_comb begin
    rd2_data = resolve_read(OUT2ADDRESS, mem_q[OUT2ADDRESS]);
  end

  assign OUT1 = rd1_data;
  assign OUT2 = rd2_data;

endmodule

// File: tb/tb_reg_file_param.sv
// Drives a default build (zero reg + bypass) and a plain build (neither) with identical
// stimulus and compares both against an array-based reference model.
module tb_reg_file_param;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D  = 32;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          WRITE = 1'b0;
  logic          CLEAR = 1'b0;
  logic [AW-1:0] INADDRESS = '0;
  logic [AW-1:0] OUT1ADDRESS = '0;
  logic [AW-1:0] OUT2ADDRESS = '0;
  logic [DW-1:0] IN = '0;
  logic [DW-1:0] a_out1, a_out2, b_out1, b_out2;
  logic          a_busy, b_busy;

  logic [DW-1:0] ma [D];
  logic [DW-1:0] mb [D];
  bit            clearing;
  int            cleared;
  int            checks = 0;
  int            errors = 0;

  always #50 CLK = ~CLK;

  reg_file_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
    .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(a_out1), .OUT2(a_out2),
    .CLEAR(CLEAR), .BUSY(a_busy)
  );

  reg_file_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
    .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(b_out1), .OUT2(b_out2),
    .CLEAR(CLEAR), .BUSY(b_busy)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
    clearing = 1'b0;
    cleared  = 0;
  endtask

  // Zero-reg + bypass build: entry 0 is always 0, an accepted write shows up immediately.
  function automatic logic [DW-1:0] exp_a(input logic [AW-1:0] addr);
    if (addr == 0) return '0;
    if (RESET && WRITE && !clearing && INADDRESS == addr) return IN;
    return ma[addr];
  endfunction

  task automatic check_ports();
    chk("a_out1", a_out1, exp_a(OUT1ADDRESS));
    chk("a_out2", a_out2, exp_a(OUT2ADDRESS));
    chk("b_out1", b_out1, mb[OUT1ADDRESS]);
    chk("b_out2", b_out2, mb[OUT2ADDRESS]);
    chk("a_busy", {31'b0, a_busy}, {31'b0, clearing});
    chk("b_busy", {31'b0, b_busy}, {31'b0, clearing});
  endtask

  task automatic apply_edge(input logic w, input logic [AW-1:0] wa,
                            input logic [DW-1:0] wd, input logic clr);
    if (clearing) begin
      ma[cleared] = '0;
      mb[cleared] = '0;
      cleared++;
      if (cleared == D) clearing = 1'b0;
    end else begin
      if (w) begin
        if (wa != 0) ma[wa] = wd;
        mb[wa] = wd;
      end
      if (clr) begin
        clearing = 1'b1;
        cleared  = 0;
      end
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic clr);
    WRITE = w; INADDRESS = wa; IN = wd;
    OUT1ADDRESS = a1; OUT2ADDRESS = a2; CLEAR = clr;
    #1 check_ports();
    $display("cycle w=%0d wa=%0d wd=%h a1=%0d a2=%0d clr=%0d | A %h %h B %h %h busy=%0d",
             w, wa, wd, a1, a2, clr, a_out1, a_out2, b_out1, b_out2, a_busy);
    @(posedge CLK);
    apply_edge(w, wa, wd, clr);
    @(negedge CLK);
  endtask

  task automatic sweep_zero(input string tag);
    WRITE = 1'b0; CLEAR = 1'b0;
    for (int a = 0; a < D; a++) begin
      OUT1ADDRESS = AW'(a); OUT2ADDRESS = AW'(a);
      #1;
      chk({tag, "_a"}, a_out1, '0);
      chk({tag, "_b"}, b_out2, '0);
    end
  endtask

  initial begin
    int n;
    logic [AW-1:0] wa;
    model_reset();
    #10 RESET = 1'b0;
    @(negedge CLK);
    sweep_zero("reset_read");
    chk("reset_busy", {31'b0, a_busy}, '0);
    @(negedge CLK);
    RESET = 1'b1;

    cycle(1'b1, 5'd2, 32'd95, 5'd0, 5'd0, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 5'd2, 5'd2, 1'b0);
    chk("read95", a_out1, 32'd95);

    cycle(1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    chk("zero_reg_a", a_out1, '0);
    chk("zero_reg_b", b_out1, 32'hDEADBEEF);

    cycle(1'b1, 5'd5, 32'd7, 5'd0, 5'd0, 1'b0);
    WRITE = 1'b1; INADDRESS = 5'd5; IN = 32'd28; OUT2ADDRESS = 5'd5;
    #1;
    chk("bypass_a", a_out2, 32'd28);
    chk("bypass_b", b_out2, 32'd7);
    cycle(1'b1, 5'd5, 32'd28, 5'd5, 5'd5, 1'b0);

    for (int i = 0; i < 150; i++) begin
      wa = AW'($urandom_range(0, D - 1));
      cycle(1'($urandom_range(0, 1)), wa, $urandom,
            AW'($urandom_range(0, D - 1)),
            ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, D - 1)), 1'b0);
    end

    for (int a = 1; a < D; a++)
      cycle(1'b1, AW'(a), DW'(a + 100), AW'(a), 5'd0, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
    n = 0;
    while (a_busy && n < 40) begin
      if (n == 10) begin
        OUT1ADDRESS = 5'd9; OUT2ADDRESS = 5'd10; CLEAR = 1'b0; WRITE = 1'b0;
        #1;
        chk("clr_addr9", a_out1, '0);
        chk("clr_addr10", a_out2, 32'd110);
        cycle(1'b0, 5'd0, 32'd0, 5'd9, 5'd10, 1'b0);
      end else if (n == 3) begin
        cycle(1'b1, 5'd4, 32'd6, 5'd4, 5'd4, 1'b1);
      end else begin
        cycle(1'b0, 5'd0, 32'd0, AW'($urandom_range(0, D - 1)),
              AW'($urandom_range(0, D - 1)), 1'b0);
      end
      n++;
    end
    chk("busy_len", DW'(n), 32'd32);
    sweep_zero("after_clear");
    cycle(1'b1, 5'd4, 32'd6, 5'd4, 5'd4, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 5'd4, 5'd4, 1'b0);
    chk("post_clear_write", a_out1, 32'd6);

    for (int i = 0; i < 300; i++) begin
      wa = AW'($urandom_range(0, D - 1));
      cycle(1'($urandom_range(0, 1)), wa, $urandom,
            AW'($urandom_range(0, D - 1)),
            ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, D - 1)),
            ($urandom_range(0, 40) == 0));
    end

    n = 0;
    while (clearing && n < 40) begin
      cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
      n++;
    end
    for (int a = 1; a < 4; a++)
      cycle(1'b1, AW'(a), DW'(a + 200), 5'd0, 5'd0, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 5'd0, 32'd0, 5'd1, 5'd3, 1'b0);
    RESET = 1'b0;
    model_reset();
    #1;
    chk("midclr_busy_a", {31'b0, a_busy}, '0);
    chk("midclr_busy_b", {31'b0, b_busy}, '0);
    sweep_zero("midclr_read");
    @(negedge CLK);
    RESET = 1'b1;
    cycle(1'b1, 5'd1, 32'd50, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 40; i++)
      cycle(1'b0, 5'd0, 32'd0, 5'd1, AW'(i % D), 1'b0);
    chk("reset_write50", a_out1, 32'd50);
    chk("no_resume_busy", {31'b0, a_busy}, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised register file for the RISC-V pipeline, the next generation of the 32x32 integer register file. Width and depth are set by parameters. It provides two combinational read ports and one synchronous write port, with an optionally hardwired-zero register 0 and optional write-to-read bypass. A sequential clear engine zeroes the whole array one entry per cycle on request and raises BUSY so the pipeline can stall. It sits between the decode stage (reads) and the writeback stage (write).

## Interface
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH entries
- ZERO_REG, 1, 1: entry 0 always reads 0 and ignores writes
- BYPASS, 1, 1: an accepted same-cycle write is forwarded to matching read ports

Ports:
- CLK  input  1  clock, all state changes on posedge
- RESET  input  1  asynchronous, active-low reset; clears all state immediately
- WRITE  input  1  write enable, sampled at posedge
- INADDRESS  input  ADDR_WIDTH  write address
- IN  input  DATA_WIDTH  write data
- OUT1ADDRESS  input  ADDR_WIDTH  read port 1 address
- OUT2ADDRESS  input  ADDR_WIDTH  read port 2 address
- OUT1  output  DATA_WIDTH  read port 1 data (combinational)
- OUT2  output  DATA_WIDTH  read port 2 data (combinational)
- CLEAR  input  1  request a full-array sequential clear, sampled at posedge
- BUSY  output  1  registered; high while the clear engine runs

## Operation
- Reset (RESET=0, asynchronous):
  - All DEPTH entries are 0.
  - FSM is IDLE, clear counter is 0, BUSY=0.
  - OUT1/OUT2 read 0.
  - Writes and CLEAR are ignored while RESET=0.
- Write acceptance: a write is accepted when WRITE=1, RESET=1 and BUSY=0. The entry at INADDRESS takes IN at that posedge.
  - ZERO_REG=1 and INADDRESS=0: the write is dropped.
  - WRITE while BUSY=1: the write is dropped. There is no queueing; the pipeline must stall on BUSY.
- Read ports:
  - OUTx = array[OUTxADDRESS].
  - ZERO_REG=1 and OUTxADDRESS=0: OUTx = 0, regardless of bypass.
  - BYPASS=1 and an accepted write to the same address this cycle: OUTx = IN combinationally.
  - BYPASS=0: OUTx shows the old value until the posedge.
  - Both ports may read the same address.
- Clear FSM has two states, IDLE and CLEARING.
  - IDLE -> CLEARING: at a posedge with CLEAR=1. Counter is set to 0 and BUSY goes to 1.
  - In CLEARING, each posedge writes 0 to array[counter] and increments the counter.
  - CLEARING -> IDLE: at the posedge that clears entry DEPTH-1. Counter returns to 0 and BUSY goes to 0.
  - CLEAR while in CLEARING is ignored; it does not restart the clear.
- Simultaneous CLEAR=1 and WRITE=1 in IDLE: the write is accepted at that edge and clearing starts on the next edge. The written value is therefore overwritten later in the sequence.
- Reads during CLEARING: entries below the counter read 0; entries at or above the counter keep their old value.
- Counter width is ADDR_WIDTH. Completion is detected by comparing with DEPTH-1, not by overflow.

## Timing
- Read latency: 0 cycles (combinational from address, array and bypass).
- Write latency: data is visible through the array 1 posedge after acceptance. With BYPASS=1 it is visible in the same cycle.
- BUSY rises 1 posedge after CLEAR is sampled.
- BUSY stays high for exactly DEPTH cycles (32 for the defaults).
- The first accepted write is possible at the posedge immediately after BUSY falls.
- RESET deasserted mid-clear: behaves as a fresh reset, with the array all 0 and FSM IDLE. The clear is not resumed.
- RESET is deasserted synchronously to CLK by the system. The block needs no internal synchroniser.

## Test plan
- Reset and read: with RESET=0, confirm OUT1/OUT2=0 for all 32 addresses. Release RESET, write 95 to addr 2, and set OUT1ADDRESS=2 on the next cycle -> OUT1=95.
- Zero register: write 0xDEADBEEF to addr 0 -> OUT1 with OUT1ADDRESS=0 stays 0 (ZERO_REG=1). Rebuild with ZERO_REG=0 and repeat -> reads 0xDEADBEEF.
- Bypass: WRITE=1, INADDRESS=5, IN=28 and OUT2ADDRESS=5 in the same cycle -> OUT2=28 before the edge with BYPASS=1, and the old value with BYPASS=0.
- Clear engine:
  - Fill addr 1..31 with the value addr+100, then pulse CLEAR for 1 cycle.
  - BUSY goes high on the next edge and stays high for 32 cycles.
  - After 10 cycles of BUSY, addr 9 reads 0 and addr 10 reads 110.
  - After BUSY falls, all entries read 0.
- Writes during clear: WRITE=1 to addr 4 with IN=6 while BUSY=1 -> addr 4 still reads 0 after the clear. The same write issued the cycle after BUSY falls -> addr 4 reads 6.
- Reset mid-clear: pull RESET low 5 cycles into the clear -> BUSY=0 and all entries 0 immediately. Release RESET and write 50 to addr 1 -> reads 50, with no further clearing.
